// File: rtl/nn_tour_pkg.sv
// nn_tour_pkg: shared sizes and state encoding for the nearest-neighbour tour block
package nn_tour_pkg;
    localparam int N_POINTS = 64;
    localparam int IDX_W    = 6;
    localparam int COORD_W  = 8;
    localparam int DIST_W   = 17;
    localparam int SUM_W    = 24;
    typedef enum logic [2:0] {IDLE, SCAN, COMMIT, CLOSE, DONE} state_t;
endpackage

// File: rtl/nn_tour_sq_dist.sv
// nn_tour_sq_dist: squared Euclidean distance between two 8-bit points
module nn_tour_sq_dist
    import nn_tour_pkg::*;
(
    input  logic [COORD_W-1:0] ax_i,
    input  logic [COORD_W-1:0] ay_i,
    input  logic [COORD_W-1:0] bx_i,
    input  logic [COORD_W-1:0] by_i,
    output logic [DIST_W-1:0]  dist_o
);
    logic [COORD_W-1:0]   dx, dy;
    logic [2*COORD_W-1:0] sx, sy;
    // absolute differences keep the squares unsigned and 16 bits wide
    always_comb begin
        dx     = (ax_i > bx_i) ? ax_i - bx_i : bx_i - ax_i;
        dy     = (ay_i > by_i) ? ay_i - by_i : by_i - ay_i;
        sx     = dx * dx;
        sy     = dy * dy;
        dist_o = DIST_W'(sx) + DIST_W'(sy);
    end
endmodule

// File: rtl/nn_tour.sv
// nn_tour: greedy nearest-neighbour tour over 64 points, one candidate per cycle
module nn_tour
    import nn_tour_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         graph_ready,
    input  logic [N_POINTS-1:0][31:0]    xs,
    input  logic [N_POINTS-1:0][31:0]    ys,
    output logic                         order_valid,
    output logic [IDX_W-1:0]             order_idx,
    output logic [SUM_W-1:0]             total_dist,
    output logic                         done
);
    state_t              state_q, state_d;
    logic [N_POINTS-1:0] visited_q, visited_d;
    logic [IDX_W-1:0]    cur_q, cur_d;
    logic [IDX_W-1:0]    j_q, j_d;
    logic [IDX_W-1:0]    best_idx_q, best_idx_d;
    logic [DIST_W-1:0]   best_cost_q, best_cost_d;
    logic                ov_q, ov_d;
    logic [IDX_W-1:0]    oidx_q, oidx_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic                done_q, done_d;
    logic [IDX_W-1:0]    b_idx;
    logic [DIST_W-1:0]   cost;
    logic                unused_bits;

    assign unused_bits = ^{xs, ys};
    // one distance unit: SCAN compares current->j, CLOSE uses current->0
    assign b_idx = (state_q == CLOSE) ? '0 : j_q;

    nn_tour_sq_dist u_sq_dist (
        .ax_i   (xs[cur_q][COORD_W-1:0]),
        .ay_i   (ys[cur_q][COORD_W-1:0]),
        .bx_i   (xs[b_idx][COORD_W-1:0]),
        .by_i   (ys[b_idx][COORD_W-1:0]),
        .dist_o (cost)
    );

    assign order_valid = ov_q;
    assign order_idx   = oidx_q;
    assign total_dist  = sum_q;
    assign done        = done_q;

    // state and datapath registers, all cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            visited_q   <= '0;
            cur_q       <= '0;
            j_q         <= '0;
            best_idx_q  <= '0;
            best_cost_q <= '1;
            ov_q        <= 1'b0;
            oidx_q      <= '0;
            sum_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            visited_q   <= visited_d;
            cur_q       <= cur_d;
            j_q         <= j_d;
            best_idx_q  <= best_idx_d;
            best_cost_q <= best_cost_d;
            ov_q        <= ov_d;
            oidx_q      <= oidx_d;
            sum_q       <= sum_d;
            done_q      <= done_d;
        end
    end

    // next-state and datapath updates; an all-ones best cost means "no best yet"
    always_comb begin
        state_d     = state_q;
        visited_d   = visited_q;
        cur_d       = cur_q;
        j_d         = j_q;
        best_idx_d  = best_idx_q;
        best_cost_d = best_cost_q;
        ov_d        = 1'b0;
        oidx_d      = oidx_q;
        sum_d       = sum_q;
        done_d      = done_q;
        case (state_q)
            IDLE: if (graph_ready) begin
                ov_d        = 1'b1;
                oidx_d      = '0;
                visited_d   = N_POINTS'(1);
                cur_d       = '0;
                j_d         = '0;
                best_idx_d  = '0;
                best_cost_d = '1;
                sum_d       = '0;
                state_d     = SCAN;
            end
            SCAN: begin
                if (!visited_q[j_q] && cost < best_cost_q) begin
                    best_cost_d = cost;
                    best_idx_d  = j_q;
                end
                j_d     = j_q + 1'b1;
                state_d = (j_q == IDX_W'(N_POINTS - 1)) ? COMMIT : SCAN;
            end
            COMMIT: begin
                ov_d        = 1'b1;
                oidx_d      = best_idx_q;
                sum_d       = sum_q + SUM_W'(best_cost_q);
                visited_d   = visited_q | (N_POINTS'(1) << best_idx_q);
                cur_d       = best_idx_q;
                best_cost_d = '1;
                j_d         = '0;
                state_d     = (&visited_d) ? CLOSE : SCAN;
            end
            CLOSE: begin
                sum_d   = sum_q + SUM_W'(cost);
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_nn_tour.sv
// tb_nn_tour: scoreboard bench for nn_tour with directed point sets
module tb_nn_tour;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              graph_ready = 1'b0;
    logic [63:0][31:0] xs, ys;
    logic              order_valid;
    logic [5:0]        order_idx;
    logic [23:0]       total_dist;
    logic              done;

    int vectors = 0;
    int errs = 0;
    int cyc = 0;
    int npulse = 0;
    int idx0_cyc = 0;
    int done_cyc = 0;
    int e;
    logic done_prev = 1'b0;
    int exp_q[$];

    nn_tour dut (
        .clk         (clk),
        .rst         (rst),
        .graph_ready (graph_ready),
        .xs          (xs),
        .ys          (ys),
        .order_valid (order_valid),
        .order_idx   (order_idx),
        .total_dist  (total_dist),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every order_valid pulse is matched against the scoreboard queue
    always @(negedge clk) begin
        if (order_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL order_idx unexpected pulse: got %0d, required no pulse", order_idx);
            end else begin
                e = exp_q.pop_front();
                if (order_idx !== 6'(e)) begin
                    errs++;
                    $display("FAIL order_idx pulse %0d: got %0d, required %0d", npulse, order_idx, e);
                end
            end
            if (order_idx == 6'd0) idx0_cyc = cyc;
            npulse++;
        end
        if (done && !done_prev) done_cyc = cyc;
        done_prev = done;
    end

    task automatic check(input string name, input longint got, input longint want);
        vectors++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        graph_ready = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run(input string name, input int want_sum);
        int p0 = npulse;
        int k = 0;
        graph_ready = 1'b1;
        while (!done && k < 6000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({name, " done"}, longint'(done), 1);
        check({name, " total_dist"}, longint'(total_dist), want_sum);
        check({name, " pulse count"}, npulse - p0, 64);
        check({name, " done latency"}, done_cyc - idx0_cyc, 4096);
        check({name, " leftover expected"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic setup_tie();
        for (int i = 0; i < 64; i++) begin
            xs[i] = 32'd200;
            ys[i] = 32'd200;
        end
        xs[0] = 0;  ys[0] = 0;
        xs[5] = 10; ys[5] = 0;
        xs[9] = 0;  ys[9] = 10;
        exp_q.push_back(0);
        exp_q.push_back(5);
        exp_q.push_back(9);
        for (int i = 1; i < 64; i++) if (i != 5 && i != 9) exp_q.push_back(i);
    endtask

    initial begin
        int p;
        int k;
        xs = '0;
        ys = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset order_valid", longint'(order_valid), 0);
        check("reset order_idx", longint'(order_idx), 0);
        check("reset total_dist", longint'(total_dist), 0);
        check("reset done", longint'(done), 0);
        rst = 1'b0;

        for (int i = 0; i < 64; i++) begin
            xs[i] = 32'd5;
            ys[i] = 32'd5;
            exp_q.push_back(i);
        end
        run("coincident", 0);

        do_reset();
        for (int i = 0; i < 64; i++) begin
            xs[i] = 32'(i);
            ys[i] = 32'd0;
            exp_q.push_back(i);
        end
        run("line", 4032);

        do_reset();
        setup_tie();
        run("tie", 156400);

        do_reset();
        setup_tie();
        p = npulse;
        k = 0;
        graph_ready = 1'b1;
        while (npulse - p < 10 && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("pulses before mid-run reset", npulse - p, 10);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrun reset order_valid", longint'(order_valid), 0);
        check("midrun reset order_idx", longint'(order_idx), 0);
        check("midrun reset total_dist", longint'(total_dist), 0);
        check("midrun reset done", longint'(done), 0);
        exp_q.delete();
        graph_ready = 1'b0;
        rst = 1'b0;
        setup_tie();
        run("tie rerun", 156400);

        do_reset();
        for (int i = 0; i < 64; i++) begin
            xs[i] = 32'hDEADBE00 | ((i % 2 == 1) ? 32'd255 : 32'd0);
            ys[i] = xs[i];
        end
        for (int i = 0; i < 64; i += 2) exp_q.push_back(i);
        for (int i = 1; i < 64; i += 2) exp_q.push_back(i);
        run("mask", 260100);

        p = npulse;
        repeat (10000) @(negedge clk);
        #1;
        check("hold done", longint'(done), 1);
        check("hold total_dist", longint'(total_dist), 260100);
        check("hold no pulses", npulse - p, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
